hit_result_collector: RTL and testbench
=======================================

// Module: hit_result_collector
// PURPOSE
//  Downstream of the ray-tracing core. Consumes the (ray id, hitT, triangle id) candidate-hit stream and
//  keeps the closest hit per ray in an internal result RAM via a 2-stage read-compare-write pipeline.
//  Counts active cycles and hits, and raises done after the core's finish flag once the pipeline drains.
//  Results are then read back by the host/bench on a 1-cycle-latency port.
// PARAMETERS
//  RAY_AW   10            ray-id address width; NUM_RAYS = 2**RAY_AW entries
//  DATA_W   32            hitT (IEEE-754 single) and triangle-id width
//  INF_T    32'h7F800000  hitT written on clear (+inf)
//  NO_TRI   32'hFFFFFFFF  triangle id written on clear
// PORTS
//  clock         in   1        single clock, rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  hit_valid     in   1        candidate hit present
//  hit_ready     out  1        collector accepts candidate this cycle
//  hit_ray_id    in   RAY_AW   ray index of candidate
//  hit_t         in   DATA_W   candidate hitT, float32
//  hit_tri_id    in   DATA_W   candidate triangle index
//  rtp_finish    in   1        core has emitted its last hit (level or pulse)
//  clear         in   1        restart pulse, honoured only in DONE
//  rd_en         in   1        readout request, honoured only in DONE
//  rd_addr       in   RAY_AW   ray index to read
//  rd_valid      out  1        readout data valid
//  rd_hit_t      out  DATA_W   stored closest hitT
//  rd_tri_id     out  DATA_W   stored triangle id
//  rd_hit        out  1        entry updated at least once since clear
//  done          out  1        all results final
//  hit_count     out  32       accepted candidates
//  drop_count    out  32       discarded candidates (negative or NaN hitT)
//  cycle_count   out  64       cycles spent in RUN + DRAIN
// BEHAVIOUR
//  Reset (async, reset_n=0): FSM=CLEAR with sweep index 0; all outputs 0; counters 0; pipeline flushed.
//  FSM:
//   CLEAR: writes {INF_T, NO_TRI, hit=0} to entry idx, one entry per cycle; hit_ready=0.
//          Goes to RUN after entry NUM_RAYS-1 is written (NUM_RAYS cycles).
//   RUN:   hit_ready=1. Handshake: a candidate is accepted when hit_valid & hit_ready.
//          When rtp_finish=1 -> DRAIN. A candidate offered in that same cycle IS accepted.
//   DRAIN: hit_ready=0. Waits until both pipeline stages are empty (at most 2 cycles) -> DONE.
//   DONE:  done=1; cycle_count frozen. rd_en serviced. clear=1 -> CLEAR (done drops next cycle).
//          rtp_finish is ignored outside RUN.
//  Pipeline (RUN/DRAIN):
//   S1: registers the candidate and issues the RAM read of hit_ray_id.
//   S2: compare, then write. Accepted hit throughput is 1/cycle; write lands 2 cycles after acceptance.
//  Discard rule: sign bit set, or exp=8'hFF with mantissa!=0 (NaN). Then drop_count++ and no RAM write;
//   otherwise hit_count++. Counters wrap at 2**32.
//  Compare: hitT values are non-negative, so they are compared as unsigned 32-bit integers.
//   Update only if new < stored (strict). On a tie the older triangle is kept.
//   An update writes {hit_t, hit_tri_id, hit=1}.
//  Hazard: if S2 writes the address S1 is reading in the same cycle, S1 uses the S2 write data
//   (forwarding), so back-to-back hits on the same ray always resolve to the true minimum.
//  Readout: rd_en at cycle N -> rd_valid=1 with data at N+1, 1-cycle pulse per request.
//   Back-to-back reads are allowed. rd_* hold their last value when rd_valid=0.
//  cycle_count increments every cycle in RUN or DRAIN and is cleared on entry to CLEAR; it wraps at 2**64.
//  Reset mid-operation: immediate abort to CLEAR; partial results are lost; a full re-sweep follows.
//  RAM has a single write port, muxed between CLEAR (sweep) and S2. A single read port is muxed between
//   S1 and readout; these never overlap by FSM construction.
// TESTING
//  1 Reset, then wait NUM_RAYS cycles -> hit_ready rises; force finish and read any entry
//    -> rd_hit_t=7F800000, rd_tri_id=FFFFFFFF, rd_hit=0.
//  2 Hits ray5: t=40A00000 tri 3, then t=40400000 tri 7, then t=40400000 tri 9, back-to-back, then finish
//    -> ray5 reads 40400000/7/hit=1; hit_count=3.
//  3 Hits ray2 t=BF800000 (negative) and ray2 t=7FC00000 (NaN) -> drop_count=2, ray2 untouched.
//  4 hit_valid with ray_id=1 t=3F800000 in the same cycle as rtp_finish=1 -> accepted; done within 3 cycles;
//    ray1 = 3F800000; cycle_count equals RUN+DRAIN cycle total and stays frozen afterwards.
//  5 reset_n low while in RUN with hits in flight -> all outputs 0 at once; re-sweep; earlier hits absent.
//  6 In DONE, clear pulse -> CLEAR sweep, counters 0, done=0; a second run produces independent results.

Source files
------------

// File: rtl/hit_result_collector_if.sv
// Candidate-hit stream from the ray-tracing core into the hit_result_collector.
// Handshake: a beat transfers on a rising clock edge where hit_valid and hit_ready are both 1;
// the producer holds hit_ray_id/hit_t/hit_tri_id stable while hit_valid=1 and hit_ready=0.
interface hit_result_collector_if #(
  parameter int RAY_AW = 10,
  parameter int DATA_W = 32
);
  logic              hit_valid;
  logic              hit_ready;
  logic [RAY_AW-1:0] hit_ray_id;
  logic [DATA_W-1:0] hit_t;
  logic [DATA_W-1:0] hit_tri_id;

  modport master (
    output hit_valid,
    output hit_ray_id,
    output hit_t,
    output hit_tri_id,
    input  hit_ready
  );

  modport slave (
    input  hit_valid,
    input  hit_ray_id,
    input  hit_t,
    input  hit_tri_id,
    output hit_ready
  );
endinterface

// File: rtl/hit_result_collector.sv
// Keeps the closest hit per ray in a result RAM using a read/compare-write pipeline,
// with activity counters, a done flag after the core finishes, and a 1-cycle readout port.
module hit_result_collector #(
  parameter int          RAY_AW = 10,
  parameter int          DATA_W = 32,
  parameter logic [31:0] INF_T  = 32'h7F800000,
  parameter logic [31:0] NO_TRI = 32'hFFFFFFFF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  hit_result_collector_if.slave hit,
  input  logic                  rtp_finish,
  input  logic                  clear,
  input  logic                  rd_en,
  input  logic [RAY_AW-1:0]     rd_addr,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_hit_t,
  output logic [DATA_W-1:0]     rd_tri_id,
  output logic                  rd_hit,
  output logic                  done,
  output logic [31:0]           hit_count,
  output logic [31:0]           drop_count,
  output logic [63:0]           cycle_count,
  output logic [1:0]            state_dbg
);
  localparam int NUM_RAYS = 2**RAY_AW;
  localparam int WORD_W   = 2*DATA_W + 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Word layout: {hit flag, hitT, triangle id}
  logic [WORD_W-1:0] mem [NUM_RAYS];

  logic [RAY_AW-1:0] clr_idx;
  logic              accept;
  logic              in_drop;

  logic              cmp_valid;
  logic [RAY_AW-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_t;
  logic [DATA_W-1:0] cmp_tri;
  logic [DATA_W-1:0] cmp_old_t;
  logic              upd;
  logic [WORD_W-1:0] upd_word;

  logic              wr_en;
  logic [RAY_AW-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [RAY_AW-1:0] rd_sel_addr;
  logic [WORD_W-1:0] rd_word;
  logic              fwd;

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (&clr_idx)   state_nxt = S_RUN;
      S_RUN:   if (rtp_finish) state_nxt = S_DRAIN;
      S_DRAIN: if (!cmp_valid) state_nxt = S_DONE;
      S_DONE:  if (clear)      state_nxt = S_CLEAR;
      default:                 state_nxt = S_CLEAR;
    endcase
  end

  assign hit.hit_ready = (state == S_RUN);
  assign accept        = hit.hit_valid & hit.hit_ready;
  assign done          = (state == S_DONE);
  assign state_dbg     = state;

  // Negative values (sign set) and NaNs never compete for closest hit
  assign in_drop = hit.hit_t[DATA_W-1] |
                   ((&hit.hit_t[DATA_W-2:DATA_W-9]) & (|hit.hit_t[DATA_W-10:0]));

  assign upd      = cmp_valid && (cmp_t < cmp_old_t);
  assign upd_word = {1'b1, cmp_t, cmp_tri};

  assign wr_en   = (state == S_CLEAR) | upd;
  assign wr_addr = (state == S_CLEAR) ? clr_idx : cmp_addr;
  assign wr_data = (state == S_CLEAR) ? {1'b0, INF_T[DATA_W-1:0], NO_TRI[DATA_W-1:0]} : upd_word;

  // Readout and the pipeline read share one port; they are never active in the same state
  assign rd_sel_addr = (state == S_DONE) ? rd_addr : hit.hit_ray_id;
  assign rd_word     = mem[rd_sel_addr];
  assign fwd         = upd && (cmp_addr == hit.hit_ray_id);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_CLEAR;
      clr_idx     <= '0;
      cmp_valid   <= 1'b0;
      cmp_addr    <= '0;
      cmp_t       <= '0;
      cmp_tri     <= '0;
      cmp_old_t   <= '0;
      hit_count   <= '0;
      drop_count  <= '0;
      cycle_count <= '0;
      rd_valid    <= 1'b0;
      rd_hit_t    <= '0;
      rd_tri_id   <= '0;
      rd_hit      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;

      cmp_valid <= accept & ~in_drop;
      if (accept) begin
        cmp_addr  <= hit.hit_ray_id;
        cmp_t     <= hit.hit_t;
        cmp_tri   <= hit.hit_tri_id;
        // A same-address write landing this edge would be missed by the RAM read
        cmp_old_t <= fwd ? cmp_t : rd_word[WORD_W-2:DATA_W];
      end

      if (state == S_DONE && clear) begin
        hit_count   <= '0;
        drop_count  <= '0;
        cycle_count <= '0;
      end else begin
        if (accept && !in_drop) hit_count  <= hit_count + 32'd1;
        if (accept && in_drop)  drop_count <= drop_count + 32'd1;
        if (state == S_RUN || state == S_DRAIN) cycle_count <= cycle_count + 64'd1;
      end

      rd_valid <= (state == S_DONE) && rd_en;
      if (state == S_DONE && rd_en) begin
        rd_hit    <= rd_word[WORD_W-1];
        rd_hit_t  <= rd_word[WORD_W-2:DATA_W];
        rd_tri_id <= rd_word[DATA_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_hit_result_collector.sv
// Directed bench for hit_result_collector with a 16-entry result RAM.
module tb_hit_result_collector;
  localparam int RAY_AW = 4;
  localparam int DATA_W = 32;
  localparam int NUM_RAYS = 2**RAY_AW;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              rtp_finish = 1'b0;
  logic              clear = 1'b0;
  logic              rd_en = 1'b0;
  logic [RAY_AW-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_hit_t;
  logic [DATA_W-1:0] rd_tri_id;
  logic              rd_hit;
  logic              done;
  logic [31:0]       hit_count;
  logic [31:0]       drop_count;
  logic [63:0]       cycle_count;
  logic [1:0]        state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;

  hit_result_collector_if #(.RAY_AW(RAY_AW), .DATA_W(DATA_W)) hit_if ();

  hit_result_collector #(.RAY_AW(RAY_AW), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .hit        (hit_if),
    .rtp_finish (rtp_finish),
    .clear      (clear),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_hit_t   (rd_hit_t),
    .rd_tri_id  (rd_tri_id),
    .rd_hit     (rd_hit),
    .done       (done),
    .hit_count  (hit_count),
    .drop_count (drop_count),
    .cycle_count(cycle_count),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (hit_if.hit_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (hit_if.hit_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s: hit_ready timeout, got %b required 1", name, hit_if.hit_ready);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s: done timeout, got %b required 1", name, done);
    end
  endtask

  task automatic send_hit(input logic [RAY_AW-1:0] ray, input logic [31:0] t, input logic [31:0] tri_id);
    hit_if.hit_valid  = 1'b1;
    hit_if.hit_ray_id = ray;
    hit_if.hit_t      = t;
    hit_if.hit_tri_id = tri_id;
    tick();
    hit_if.hit_valid  = 1'b0;
  endtask

  task automatic finish_run(input string name);
    rtp_finish = 1'b1;
    tick();
    rtp_finish = 1'b0;
    wait_done(name);
  endtask

  task automatic restart(input string name);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_ready(name);
  endtask

  task automatic read_entry(input logic [RAY_AW-1:0] addr, output logic v,
                            output logic [31:0] t, output logic [31:0] tri_id, output logic h);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en   = 1'b0;
    v = rd_valid; t = rd_hit_t; tri_id = rd_tri_id; h = rd_hit;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic v, h;
    logic [31:0] t, tr;
    hit_if.hit_valid = 1'b0; hit_if.hit_ray_id = '0; hit_if.hit_t = '0; hit_if.hit_tri_id = '0;
    reset_n = 1'b0;
    tick(); tick();
    vec_cnt++;
    if ({hit_if.hit_ready, done, rd_valid, rd_hit} !== 4'b0000) begin
      err_cnt++; $display("FAIL reset_flags: got %b required 0000", {hit_if.hit_ready, done, rd_valid, rd_hit});
    end
    vec_cnt++;
    if ({hit_count, drop_count, cycle_count} !== 128'd0) begin
      err_cnt++; $display("FAIL reset_counters: got %h required 0", {hit_count, drop_count, cycle_count});
    end
    reset_n = 1'b1;
    for (int i = 0; i < NUM_RAYS - 1; i++) tick();
    vec_cnt++;
    if (hit_if.hit_ready !== 1'b0) begin
      err_cnt++; $display("FAIL sweep_len_early: hit_ready got %b required 0", hit_if.hit_ready);
    end
    tick();
    vec_cnt++;
    if (hit_if.hit_ready !== 1'b1) begin
      err_cnt++; $display("FAIL sweep_len: hit_ready got %b required 1", hit_if.hit_ready);
    end
    finish_run("reset_finish");
    vec_cnt++;
    if (cycle_count !== 64'd2) begin
      err_cnt++; $display("FAIL reset_cycle_count: got %0d required 2", cycle_count);
    end
    read_entry(4'd0, v, t, tr, h);
    vec_cnt++;
    if ({v, t, tr, h} !== {1'b1, 32'h7F800000, 32'hFFFFFFFF, 1'b0}) begin
      err_cnt++; $display("FAIL cleared_entry0: got v=%b t=%h tri=%h hit=%b required 1/7f800000/ffffffff/0", v, t, tr, h);
    end
    read_entry(4'd15, v, t, tr, h);
    vec_cnt++;
    if ({v, t, tr, h} !== {1'b1, 32'h7F800000, 32'hFFFFFFFF, 1'b0}) begin
      err_cnt++; $display("FAIL cleared_entry15: got v=%b t=%h tri=%h hit=%b required 1/7f800000/ffffffff/0", v, t, tr, h);
    end
  endtask

  task automatic test_closest();
    logic v, h;
    logic [31:0] t, tr;
    restart("closest_restart");
    send_hit(4'd5, 32'h40A00000, 32'd3);
    send_hit(4'd5, 32'h40400000, 32'd7);
    send_hit(4'd5, 32'h40400000, 32'd9);
    finish_run("closest_finish");
    read_entry(4'd5, v, t, tr, h);
    vec_cnt++;
    if ({v, t, tr, h} !== {1'b1, 32'h40400000, 32'd7, 1'b1}) begin
      err_cnt++; $display("FAIL closest_ray5: got v=%b t=%h tri=%0d hit=%b required 1/40400000/7/1", v, t, tr, h);
    end
    read_entry(4'd4, v, t, tr, h);
    vec_cnt++;
    if ({t, tr, h} !== {32'h7F800000, 32'hFFFFFFFF, 1'b0}) begin
      err_cnt++; $display("FAIL closest_ray4_untouched: got t=%h tri=%h hit=%b required 7f800000/ffffffff/0", t, tr, h);
    end
    vec_cnt++;
    if ({hit_count, drop_count} !== {32'd3, 32'd0}) begin
      err_cnt++; $display("FAIL closest_counts: got hits=%0d drops=%0d required 3/0", hit_count, drop_count);
    end
  endtask

  task automatic test_drop();
    logic v, h;
    logic [31:0] t, tr;
    restart("drop_restart");
    send_hit(4'd2, 32'hBF800000, 32'd1);
    send_hit(4'd2, 32'h7FC00000, 32'd2);
    send_hit(4'd3, 32'h7F800001, 32'd3);
    send_hit(4'd2, 32'h7F800000, 32'd4);
    finish_run("drop_finish");
    vec_cnt++;
    if ({hit_count, drop_count} !== {32'd1, 32'd3}) begin
      err_cnt++; $display("FAIL drop_counts: got hits=%0d drops=%0d required 1/3", hit_count, drop_count);
    end
    read_entry(4'd2, v, t, tr, h);
    vec_cnt++;
    if ({t, tr, h} !== {32'h7F800000, 32'hFFFFFFFF, 1'b0}) begin
      err_cnt++; $display("FAIL drop_ray2: got t=%h tri=%h hit=%b required 7f800000/ffffffff/0", t, tr, h);
    end
    read_entry(4'd3, v, t, tr, h);
    vec_cnt++;
    if ({t, tr, h} !== {32'h7F800000, 32'hFFFFFFFF, 1'b0}) begin
      err_cnt++; $display("FAIL drop_ray3: got t=%h tri=%h hit=%b required 7f800000/ffffffff/0", t, tr, h);
    end
  endtask

  task automatic test_finish_same_cycle();
    logic v, h;
    logic [31:0] t, tr;
    restart("fin_restart");
    tick(); tick(); tick();
    hit_if.hit_valid  = 1'b1;
    hit_if.hit_ray_id = 4'd1;
    hit_if.hit_t      = 32'h3F800000;
    hit_if.hit_tri_id = 32'd4;
    rtp_finish        = 1'b1;
    tick();
    hit_if.hit_valid  = 1'b0;
    rtp_finish        = 1'b0;
    vec_cnt++;
    if ({done, hit_if.hit_ready, hit_count} !== {1'b0, 1'b0, 32'd1}) begin
      err_cnt++; $display("FAIL fin_accept: got done=%b ready=%b hits=%0d required 0/0/1", done, hit_if.hit_ready, hit_count);
    end
    tick();
    vec_cnt++;
    if (done !== 1'b0) begin
      err_cnt++; $display("FAIL fin_drain: done got %b required 0", done);
    end
    tick();
    vec_cnt++;
    if (done !== 1'b1) begin
      err_cnt++; $display("FAIL fin_done_latency: done got %b required 1", done);
    end
    vec_cnt++;
    if (cycle_count !== 64'd6) begin
      err_cnt++; $display("FAIL fin_cycle_count: got %0d required 6", cycle_count);
    end
    for (int i = 0; i < 5; i++) tick();
    vec_cnt++;
    if (cycle_count !== 64'd6) begin
      err_cnt++; $display("FAIL fin_cycle_frozen: got %0d required 6", cycle_count);
    end
    read_entry(4'd1, v, t, tr, h);
    vec_cnt++;
    if ({v, t, tr, h} !== {1'b1, 32'h3F800000, 32'd4, 1'b1}) begin
      err_cnt++; $display("FAIL fin_ray1: got v=%b t=%h tri=%0d hit=%b required 1/3f800000/4/1", v, t, tr, h);
    end
  endtask

  task automatic test_reset_mid_run();
    logic v, h;
    logic [31:0] t, tr;
    restart("abort_restart");
    send_hit(4'd6, 32'h40000000, 32'd5);
    send_hit(4'd6, 32'h3F000000, 32'd6);
    #2;
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({hit_if.hit_ready, done, rd_valid, rd_hit, state_dbg} !== 6'b0) begin
      err_cnt++; $display("FAIL abort_flags: got %b required 000000", {hit_if.hit_ready, done, rd_valid, rd_hit, state_dbg});
    end
    vec_cnt++;
    if ({hit_count, cycle_count, rd_hit_t, rd_tri_id} !== 160'd0) begin
      err_cnt++; $display("FAIL abort_regs: got hits=%0d cycles=%0d rd_t=%h rd_tri=%h required 0", hit_count, cycle_count, rd_hit_t, rd_tri_id);
    end
    tick();
    reset_n = 1'b1;
    wait_ready("abort_sweep");
    finish_run("abort_finish");
    read_entry(4'd6, v, t, tr, h);
    vec_cnt++;
    if ({t, tr, h, hit_count} !== {32'h7F800000, 32'hFFFFFFFF, 1'b0, 32'd0}) begin
      err_cnt++; $display("FAIL abort_ray6: got t=%h tri=%h hit=%b hits=%0d required 7f800000/ffffffff/0/0", t, tr, h, hit_count);
    end
  endtask

  task automatic test_clear_rerun();
    logic v, h;
    logic [31:0] t, tr;
    restart("clr_restart1");
    send_hit(4'd9, 32'h41000000, 32'd1);
    send_hit(4'd10, 32'h40800000, 32'd12);
    finish_run("clr_finish1");
    read_entry(4'd9, v, t, tr, h);
    vec_cnt++;
    if ({t, tr, h} !== {32'h41000000, 32'd1, 1'b1}) begin
      err_cnt++; $display("FAIL clr_run1_ray9: got t=%h tri=%0d hit=%b required 41000000/1/1", t, tr, h);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vec_cnt++;
    if ({done, hit_if.hit_ready, hit_count, drop_count, cycle_count} !== 130'd0) begin
      err_cnt++; $display("FAIL clr_entry: got done=%b ready=%b hits=%0d drops=%0d cycles=%0d required all 0",
                          done, hit_if.hit_ready, hit_count, drop_count, cycle_count);
    end
    wait_ready("clr_sweep");
    send_hit(4'd9, 32'h41200000, 32'd2);
    finish_run("clr_finish2");
    // Back-to-back reads, then an idle cycle where the data must hold
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    vec_cnt++;
    if ({rd_valid, rd_hit_t, rd_tri_id, rd_hit} !== {1'b1, 32'h41200000, 32'd2, 1'b1}) begin
      err_cnt++; $display("FAIL clr_run2_ray9: got v=%b t=%h tri=%0d hit=%b required 1/41200000/2/1", rd_valid, rd_hit_t, rd_tri_id, rd_hit);
    end
    rd_addr = 4'd10;
    tick();
    rd_en = 1'b0;
    vec_cnt++;
    if ({rd_valid, rd_hit_t, rd_tri_id, rd_hit} !== {1'b1, 32'h7F800000, 32'hFFFFFFFF, 1'b0}) begin
      err_cnt++; $display("FAIL clr_run2_ray10: got v=%b t=%h tri=%h hit=%b required 1/7f800000/ffffffff/0", rd_valid, rd_hit_t, rd_tri_id, rd_hit);
    end
    tick();
    vec_cnt++;
    if ({rd_valid, rd_hit_t, rd_tri_id} !== {1'b0, 32'h7F800000, 32'hFFFFFFFF}) begin
      err_cnt++; $display("FAIL rd_hold: got v=%b t=%h tri=%h required 0/7f800000/ffffffff", rd_valid, rd_hit_t, rd_tri_id);
    end
  endtask

  initial begin
    test_reset();
    test_closest();
    test_drop();
    test_finish_same_cycle();
    test_reset_mid_run();
    test_clear_rerun();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
